// File: rtl/powlib_pipe.sv
// Elastic S-stage register pipeline with ready/valid on both sides.
// Empty stages are refilled even while the output is stalled, and flush drops every in-flight beat.
module powlib_pipe #(
  parameter int unsigned          W    = 16,
  parameter int unsigned          S    = 2,
  parameter logic [W-1:0]         INIT = '0,
  localparam int unsigned         CW   = $clog2(S+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_d,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic [W-1:0]  out_q,
  output logic          out_vld,
  input  logic          out_rdy,
  input  logic          flush,
  output logic [CW-1:0] cnt
);

  generate
    if (S < 1) begin : g_bad_depth
      $error("powlib_pipe: S must be at least 1");
    end
  endgenerate

  logic [W-1:0]  d_reg [S];
  logic [S-1:0]  v_reg;
  logic [S-1:0]  v_next;
  logic [S-1:0]  adv;
  logic [S-1:0]  ld;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // A stage may advance when it is empty or everything downstream advances.
  always_comb begin
    adv = '0;
    adv[S-1] = ~v_reg[S-1] | out_rdy;
    for (int i = int'(S) - 2; i >= 0; i--) begin
      adv[i] = ~v_reg[i] | adv[i+1];
    end
  end

  assign in_rdy = adv[0] & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < int'(S); gi++) begin : g_stage
      logic up_vld;
      logic [W-1:0] up_d;

      if (gi == 0) begin : g_head
        assign up_vld = in_vld & in_rdy;
        assign up_d   = in_d;
      end else begin : g_body
        assign up_vld = v_reg[gi-1];
        assign up_d   = d_reg[gi-1];
      end

      assign v_next[gi] = flush ? 1'b0 : (adv[gi] ? up_vld : v_reg[gi]);
      // Data only moves with a valid beat, so out_q keeps its last value between beats.
      assign ld[gi]     = ~flush & adv[gi] & up_vld;

      always_ff @(posedge clk) begin
        if (rst) begin
          d_reg[gi] <= INIT;
        end else if (ld[gi]) begin
          d_reg[gi] <= up_d;
        end
      end
    end
  endgenerate

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < int'(S); i++) begin
      cnt_next = cnt_next + CW'(v_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg   <= '0;
      cnt_reg <= '0;
    end else begin
      v_reg   <= v_next;
      cnt_reg <= cnt_next;
    end
  end

  assign out_q   = d_reg[S-1];
  assign out_vld = v_reg[S-1];
  assign cnt     = cnt_reg;

endmodule

// File: tb/tb_powlib_pipe.sv
// Directed and randomized checks of powlib_pipe with S=3, W=8, INIT=8'hA5.
module tb_powlib_pipe;

  localparam int W  = 8;
  localparam int S  = 3;
  localparam int CW = $clog2(S+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_d;
  logic          in_vld;
  logic          in_rdy;
  logic [W-1:0]  out_q;
  logic          out_vld;
  logic          out_rdy;
  logic          flush;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_d;
  int acc;

  powlib_pipe #(.W(W), .S(S), .INIT(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .in_d(in_d), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_q(out_q), .out_vld(out_vld), .out_rdy(out_rdy),
    .flush(flush), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here, outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_d = '0; in_vld = 1'b0; out_rdy = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_vld", 32'(out_vld), 0);
    check("rst_out_q", 32'(out_q), 32'hA5);
    check("rst_cnt", 32'(cnt), 0);
    check("rst_in_rdy", 32'(in_rdy), 1);

    // Latency: one beat, visible at the output exactly S cycles later.
    for (int c = 0; c < 5; c++) begin
      tick();
      in_vld = (c == 0); in_d = 8'h11; out_rdy = 1'b1;
      #1;
      check($sformatf("lat_vld_c%0d", c), 32'(out_vld), 32'(c == 3));
      if (c == 3) check("lat_q", 32'(out_q), 32'h11);
      if (c == 1) check("lat_cnt1", 32'(cnt), 1);
      if (c == 4) check("lat_cnt0", 32'(cnt), 0);
    end

    // Full throughput: 16 back-to-back beats.
    for (int c = 0; c < 19; c++) begin
      tick();
      in_vld = (c < 16); in_d = 8'(c); out_rdy = 1'b1;
      #1;
      if (c < 16) check($sformatf("tp_in_rdy_c%0d", c), 32'(in_rdy), 1);
      if (c >= 3) begin
        check($sformatf("tp_vld_c%0d", c), 32'(out_vld), 1);
        check($sformatf("tp_q_c%0d", c), 32'(out_q), 32'(c - 3));
      end
    end

    // Fill with gaps while stalled; bubbles collapse so exactly S beats fit.
    acc = 0;
    for (int a = 0; a < 5; a++) begin
      tick();
      in_vld = 1'b1; in_d = 8'(8'h20 + a); out_rdy = 1'b0;
      #1;
      if (in_rdy) acc++;
      tick();
      in_vld = 1'b0;
    end
    tick();
    in_vld = 1'b1; in_d = 8'h2F;
    #1;
    check("fill_acc", 32'(acc), 3);
    check("fill_in_rdy", 32'(in_rdy), 0);
    check("fill_cnt", 32'(cnt), 3);
    for (int c = 0; c < 4; c++) begin
      tick();
      in_vld = 1'b0; out_rdy = 1'b1;
      #1;
      if (c == 0) check("drain_in_rdy", 32'(in_rdy), 1);
      check($sformatf("drain_vld_c%0d", c), 32'(out_vld), 32'(c < 3));
      if (c < 3) check($sformatf("drain_q_c%0d", c), 32'(out_q), 32'(8'h20 + c));
    end
    check("drain_cnt", 32'(cnt), 0);

    // Flush with the pipe full: head beat still delivered, input refused.
    for (int c = 0; c < 3; c++) begin
      tick();
      in_vld = 1'b1; in_d = 8'(8'h30 + c); out_rdy = 1'b0;
      #1;
      check($sformatf("fl_fill_rdy_c%0d", c), 32'(in_rdy), 1);
    end
    tick();
    in_vld = 1'b1; in_d = 8'h33; out_rdy = 1'b1; flush = 1'b1;
    #1;
    check("fl_cnt_before", 32'(cnt), 3);
    check("fl_in_rdy", 32'(in_rdy), 0);
    check("fl_head_vld", 32'(out_vld), 1);
    check("fl_head_q", 32'(out_q), 32'h30);
    for (int c = 0; c < 3; c++) begin
      tick();
      flush = 1'b0; in_vld = 1'b0;
      #1;
      check($sformatf("fl_after_vld_c%0d", c), 32'(out_vld), 0);
      check($sformatf("fl_after_cnt_c%0d", c), 32'(cnt), 0);
    end
    check("fl_q_held", 32'(out_q), 32'h30);

    // Random traffic with a reset in the middle, checked against a queue.
    sb_q.delete();
    for (int c = 0; c < 10000 + 8; c++) begin
      tick();
      if (c < 10000) begin
        in_vld  = 1'($urandom_range(0, 1));
        out_rdy = ($urandom_range(0, 3) != 0);
      end else begin
        in_vld  = 1'b0;
        out_rdy = 1'b1;
      end
      in_d = 8'($urandom);
      rst  = (c == 5000);
      #1;
      if (rst) begin
        sb_q.delete();
      end else begin
        check("rnd_cnt", 32'(cnt), 32'(sb_q.size()));
        if (out_vld && out_rdy) begin
          if (sb_q.size() == 0) begin
            check("rnd_spurious", 32'(out_vld), 0);
          end else begin
            exp_d = sb_q.pop_front();
            check("rnd_data", 32'(out_q), 32'(exp_d));
          end
        end
        if (in_vld && in_rdy) sb_q.push_back(in_d);
      end
    end
    rst = 1'b0;
    check("rnd_all_delivered", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/powlib_pipe.md
Name: powlib_pipe

Overview:
- Parametrised, elastic multi-stage pipeline register with a ready/valid handshake on both sides.
- Next generation of the team's single flipflop: configurable depth, per-stage valid tracking and bubble collapsing.
- Adds downstream backpressure, a synchronous flush and an occupancy count.
- Used to break timing paths on streaming datapaths without losing or duplicating beats.

Parameters:
- W, 16, data width in bits (W >= 1).
- S, 2, number of register stages (S >= 1; S = 0 is illegal and must fail elaboration).
- INIT, 0 (W bits), value loaded into every data stage on reset.
- CW, $clog2(S+1), width of the occupancy count (derived; not to be overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_d  in  W  input data.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  pipeline can accept a beat this cycle.
- out_q  out  W  output data (stage S-1 register).
- out_vld  out  1  output beat valid (stage S-1 valid).
- out_rdy  in  1  downstream accepts a beat this cycle.
- flush  in  1  synchronous clear of all valid bits.
- cnt  out  CW  number of valid stages.

Behaviour:
- State:
  - Per stage i (0..S-1): data register d[i] (W bits) and valid bit v[i].
  - Stage 0 faces the input; stage S-1 drives out_q/out_vld directly.
  - No combinational path from in_d to out_q.
- Advance terms (combinational):
  - adv[S-1] = ~v[S-1] | out_rdy.
  - adv[i] = ~v[i] | adv[i+1] for i < S-1.
  - The ready chain is intentionally combinational from out_rdy to in_rdy (bubble collapsing).
- in_rdy = adv[0] & ~flush.
- Transfers:
  - Input transfer = in_vld & in_rdy.
  - Output transfer = out_vld & out_rdy.
- Update rule when adv[i] = 1 and flush = 0:
  - v[i] <= (i==0 ? in_vld & in_rdy : v[i-1]).
  - d[i] loads the upstream data (in_d or d[i-1]) only when the incoming valid is 1; otherwise d[i] holds.
- Stage hold: when adv[i] = 0, d[i] and v[i] hold (stall).
- Latency: an input transfer in cycle n into an empty, unstalled pipe gives out_vld = 1 with that data in cycle n+S.
- Throughput: 1 beat/cycle sustained while out_rdy = 1.
- Bubbles: an empty stage is filled from upstream even when downstream is stalled.
- Stalled pipe: a full pipe with out_rdy = 0 gives in_rdy = 0. A full pipe with out_rdy = 1 gives in_rdy = 1 (simultaneous in and out transfer).
- cnt:
  - Registered popcount of v, updated with v.
  - Range 0..S; cnt = S exactly when all stages are valid.
- flush:
  - Precedence: rst > flush > normal operation.
  - On the edge where flush = 1: all v[i] <= 0 and cnt <= 0; d[i] hold; in_rdy = 0, so no input is accepted.
  - An output transfer occurring in the flush cycle (out_vld & out_rdy) still counts as delivered.
- Reset (rst = 1 at an edge):
  - v[i] <= 0 and d[i] <= INIT for all i, so out_vld = 0, out_q = INIT, cnt = 0.
  - in_rdy = 1 in the cycle after reset (rst = 0, flush = 0).
  - Reset mid-stream discards all in-flight beats; no partial beat may emerge afterwards.
- Ordering: beats exit in acceptance order; no beat is dropped, duplicated or reordered under any out_rdy pattern.
- Idle inputs: in_d is ignored when in_vld = 0. Data on out_q while out_vld = 0 is don't-care to consumers, but must equal the last held value (no X after reset).

Test Plan:
- Reset values (S=3, W=8, INIT=8'hA5): assert rst 2 cycles -> out_vld=0, out_q=8'hA5, cnt=0, in_rdy=1.
- Latency (S=3, out_rdy=1): single beat 8'h11 in cycle 0 -> out_vld=1, out_q=8'h11 in cycle 3 only; cnt returns to 0.
- Full throughput: stream 8'h00..8'h0F back-to-back, out_rdy=1 -> identical sequence out, 1 beat/cycle, in_rdy never drops.
- Fill and bubble collapse:
  - Setup: out_rdy=0, send beats with one idle cycle between each.
  - Expected: exactly 3 beats accepted; then in_rdy=0, cnt=3.
  - Then raise out_rdy: beats drain in order and in_rdy=1 in the same cycle as the first output transfer.
- Flush: pipe holding 3 beats, pulse flush with out_rdy=1 and in_vld=1 -> head beat delivered that cycle, input not accepted, next cycle out_vld=0, cnt=0.
- Random: random in_vld/out_rdy over 10k cycles, with a mid-stream rst -> scoreboard shows in-order, lossless transfer; nothing in flight at reset emerges; cnt always equals the scoreboard occupancy.
